// File: rtl/barrier_scheduler_pkg.sv
// rtl/barrier_scheduler_pkg.sv - shared game types and constants for the barrier scheduler
package barrier_scheduler_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        LEFT  = 2'b01,
        MID   = 2'b10,
        RIGHT = 2'b11
    } lane_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GAP   = 2'b01,
        SHOW  = 2'b10,
        CLEAR = 2'b11
    } sched_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Cycles LEFT -> MID -> RIGHT -> LEFT; NONE is never a valid previous lane.
    function automatic logic [1:0] lane_rotate(input logic [1:0] lane);
        return (lane == RIGHT) ? LEFT : lane + 2'd1;
    endfunction

endpackage

// File: rtl/barrier_scheduler_if.sv
// rtl/barrier_scheduler_if.sv - frame/collision inputs and lane/score outputs of the scheduler
interface barrier_scheduler_if;
    logic       i_v_sync;
    logic       i_run;
    logic       i_penguin_hit;
    logic [1:0] o_active;
    logic       o_dodged;
    logic       o_hit_wave;
    logic [7:0] o_wave_count;
    logic [3:0] o_level;

    modport master (
        output i_v_sync, i_run, i_penguin_hit,
        input  o_active, o_dodged, o_hit_wave, o_wave_count, o_level
    );

    modport slave (
        input  i_v_sync, i_run, i_penguin_hit,
        output o_active, o_dodged, o_hit_wave, o_wave_count, o_level
    );
endinterface

// File: rtl/barrier_scheduler_lfsr16.sv
// rtl/barrier_scheduler_lfsr16.sv - enable-gated 16-bit right-shift Galois LFSR
module lfsr16
    import barrier_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic [1:0] nxt_lsb_o
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign nxt_lsb_o = lfsr_d[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/barrier_scheduler.sv
// rtl/barrier_scheduler.sv - frame-paced barrier wave scheduler: gap, show one lane, one-frame clear
module barrier_scheduler
    import barrier_scheduler_pkg::*;
#(
    parameter int          SHOW_FRAMES     = 90,
    parameter int          GAP_INIT        = 60,
    parameter int          GAP_MIN         = 20,
    parameter int          GAP_STEP        = 4,
    parameter int          WAVES_PER_LEVEL = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    barrier_scheduler_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_GAP   = GAP;
    localparam logic [1:0] S_SHOW  = SHOW;
    localparam logic [1:0] S_CLEAR = CLEAR;

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] active_q, active_d;
    logic [1:0] prev_q, prev_d;
    logic [7:0] wc_q, wc_d;
    logic [3:0] level_q, level_d;
    logic       dodged_q, dodged_d;
    logic       hitw_q, hitw_d;
    logic       vs_q, hit_q;

    logic              tick, hit_e, lfsr_en;
    logic [1:0]        cand, lane_sel;
    logic [7:0]        wc_inc, gap_len;
    logic signed [8:0] gap_raw;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .en_i      (lfsr_en),
        .nxt_lsb_o (cand)
    );

    assign tick     = bus.i_v_sync & ~vs_q;
    assign hit_e    = bus.i_penguin_hit & ~hit_q;
    assign lane_sel = (cand == NONE) ? lane_rotate(prev_q) : cand;
    assign wc_inc   = (wc_q == 8'hFF) ? wc_q : wc_q + 8'd1;

    // Shrinking gap evaluated in signed 9-bit so an over-stepped level clamps instead of wrapping.
    always_comb begin
        gap_raw = $signed(9'(GAP_INIT) - 9'(level_q) * 9'(GAP_STEP));
        gap_len = (gap_raw < $signed(9'(GAP_MIN))) ? 8'(GAP_MIN) : gap_raw[7:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        prev_d   = prev_q;
        wc_d     = wc_q;
        level_d  = level_q;
        dodged_d = 1'b0;
        hitw_d   = 1'b0;
        lfsr_en  = 1'b0;
        if (!bus.i_run) begin
            state_d  = S_IDLE;
            active_d = NONE;
        end else begin
            case (state_q)
                S_IDLE: if (tick) begin
                    wc_d    = 8'd0;
                    level_d = 4'd0;
                    cnt_d   = 8'(GAP_INIT);
                    state_d = S_GAP;
                end
                S_GAP: if (tick) begin
                    if (cnt_q == 8'd1) begin
                        lfsr_en  = 1'b1;
                        active_d = lane_sel;
                        prev_d   = lane_sel;
                        cnt_d    = 8'(SHOW_FRAMES);
                        state_d  = S_SHOW;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_SHOW: if (hit_e) begin
                    hitw_d   = 1'b1;
                    active_d = NONE;
                    state_d  = S_CLEAR;
                end else if (tick) begin
                    if (cnt_q == 8'd1) begin
                        dodged_d = 1'b1;
                        wc_d     = wc_inc;
                        if ((wc_inc % 8'(WAVES_PER_LEVEL)) == 8'd0 && level_q != 4'hF)
                            level_d = level_q + 4'd1;
                        active_d = NONE;
                        state_d  = S_CLEAR;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_CLEAR: if (tick) begin
                    cnt_d   = gap_len;
                    state_d = S_GAP;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            active_q <= NONE;
            prev_q   <= MID;
            wc_q     <= 8'd0;
            level_q  <= 4'd0;
            dodged_q <= 1'b0;
            hitw_q   <= 1'b0;
            vs_q     <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            prev_q   <= prev_d;
            wc_q     <= wc_d;
            level_q  <= level_d;
            dodged_q <= dodged_d;
            hitw_q   <= hitw_d;
            vs_q     <= bus.i_v_sync;
            hit_q    <= bus.i_penguin_hit;
        end
    end

    assign bus.o_active     = active_q;
    assign bus.o_dodged     = dodged_q;
    assign bus.o_hit_wave   = hitw_q;
    assign bus.o_wave_count = wc_q;
    assign bus.o_level      = level_q;
endmodule

// File: tb/tb_barrier_scheduler.sv
// tb/tb_barrier_scheduler.sv - randomized wave-level checks of barrier_scheduler against a rule model
module tb_barrier_scheduler;
    localparam int SHOW = 3;
    localparam int GI   = 10;
    localparam int GM   = 3;
    localparam int GS   = 4;
    localparam int WPL  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    barrier_scheduler_if bus ();

    barrier_scheduler #(
        .SHOW_FRAMES(SHOW), .GAP_INIT(GI), .GAP_MIN(GM), .GAP_STEP(GS),
        .WAVES_PER_LEVEL(WPL), .LFSR_SEED(SEED)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    int          m_prev, m_wc, m_lv;

    int          nd, nh;
    logic [1:0]  a_tick, a_mid;
    logic [31:0] r_all;
    int          ramp [6] = '{10, 10, 6, 6, 3, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = SEED;
        m_prev = 2;
        m_wc   = 0;
        m_lv   = 0;
    endtask

    task automatic next_lane(output int lane);
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        if (m_lfsr[1:0] == 2'b00) lane = (m_prev == 3) ? 1 : m_prev + 1;
        else                      lane = int'(m_lfsr[1:0]);
        m_prev = lane;
    endtask

    function automatic int model_gap();
        int g;
        g = GI - m_lv * GS;
        return (g < GM) ? GM : g;
    endfunction

    task automatic sample();
        nd = nd + (bus.o_dodged ? 1 : 0);
        nh = nh + (bus.o_hit_wave ? 1 : 0);
    endtask

    // One 3-cycle frame; mode 1 hit with tick, 2 hit mid-frame, 3 drop run mid-frame, 4 reset mid-frame.
    task automatic frame(input int mode);
        nd = 0;
        nh = 0;
        @(negedge clk); sample();
        bus.i_v_sync = 1'b1;
        if (mode == 1) bus.i_penguin_hit = 1'b1;
        @(negedge clk); sample();
        a_tick = bus.o_active;
        bus.i_v_sync = 1'b0;
        if (mode == 2) bus.i_penguin_hit = 1'b1;
        if (mode == 3) bus.i_run = 1'b0;
        if (mode == 4) begin
            rst = 1'b1;
            #1;
            r_all = {bus.o_active, bus.o_dodged, bus.o_hit_wave, bus.o_wave_count, bus.o_level};
        end
        @(negedge clk); sample();
        a_mid = bus.o_active;
        if (mode == 4) rst = 1'b0;
    endtask

    task automatic start_game();
        bus.i_run = 1'b1;
        bus.i_penguin_hit = 1'b0;
        m_wc = 0;
        m_lv = 0;
        frame(0);
        check("start_active", 32'(a_tick), 32'd0);
        check("start_wc", 32'(bus.o_wave_count), 32'd0);
        check("start_level", 32'(bus.o_level), 32'd0);
    endtask

    task automatic run_wave(input int hk, input int hm, output int meas);
        int g, lane, c;
        g = model_gap();
        next_lane(lane);
        c = 0;
        do begin
            frame(0);
            c++;
            check("gap_pulses", 32'(nd + nh), 32'd0);
            if (c == 1) bus.i_penguin_hit = 1'b0;
        end while (a_tick == 2'b00 && c < 300);
        meas = c;
        check("gap_len", 32'(c), 32'(g));
        check("lane", 32'(a_tick), 32'(lane));
        for (int k = 1; k <= SHOW; k++) begin
            frame((k == hk) ? hm : 0);
            if (k == hk && hm == 4) begin
                check("reset_outputs", r_all, 32'd0);
                model_reset();
                return;
            end
            if (k == hk && hm == 3) begin
                check("drop_pre_active", 32'(a_tick), 32'(lane));
                check("drop_active", 32'(a_mid), 32'd0);
                check("drop_pulses", 32'(nd + nh), 32'd0);
                repeat (2) @(negedge clk);
                check("drop_wc_hold", 32'(bus.o_wave_count), 32'(m_wc));
                check("drop_level_hold", 32'(bus.o_level), 32'(m_lv));
                return;
            end
            if (k == hk) begin
                if (hm == 1) begin
                    check("hit_tick_active", 32'(a_tick), 32'd0);
                end else begin
                    check("hit_pre_active", 32'(a_tick), 32'(lane));
                    check("hit_mid_active", 32'(a_mid), 32'd0);
                end
                check("hit_pulse", 32'(nh), 32'd1);
                check("hit_no_dodge", 32'(nd), 32'd0);
                check("hit_wc", 32'(bus.o_wave_count), 32'(m_wc));
                break;
            end
            if (k < SHOW) begin
                check("show_active", 32'(a_tick), 32'(lane));
                check("show_pulses", 32'(nd + nh), 32'd0);
            end else begin
                m_wc = (m_wc == 255) ? 255 : m_wc + 1;
                if (m_wc % WPL == 0 && m_lv < 15) m_lv++;
                check("end_active", 32'(a_tick), 32'd0);
                check("dodge_pulse", 32'(nd), 32'd1);
                check("dodge_no_hit", 32'(nh), 32'd0);
                check("dodge_wc", 32'(bus.o_wave_count), 32'(m_wc));
                check("dodge_level", 32'(bus.o_level), 32'(m_lv));
            end
        end
        frame(0);
        check("clear_active", 32'(a_tick), 32'd0);
        check("clear_pulses", 32'(nd + nh), 32'd0);
    endtask

    initial begin
        int meas, r, k, m;
        rst = 1'b1;
        bus.i_v_sync = 1'b0;
        bus.i_run = 1'b0;
        bus.i_penguin_hit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active", 32'(bus.o_active), 32'd0);
        check("rst_dodged", 32'(bus.o_dodged), 32'd0);
        check("rst_hit", 32'(bus.o_hit_wave), 32'd0);
        check("rst_wc", 32'(bus.o_wave_count), 32'd0);
        check("rst_level", 32'(bus.o_level), 32'd0);
        rst = 1'b0;
        model_reset();

        start_game();
        for (int w = 0; w < 6; w++) begin
            run_wave(0, 0, meas);
            check("ramp_gap", 32'(meas), 32'(ramp[w]));
        end
        check("ramp_level", 32'(bus.o_level), 32'd3);
        run_wave(SHOW, 1, meas);
        run_wave(2, 2, meas);

        for (int w = 0; w < 1000; w++) begin
            r = int'($urandom_range(9, 0));
            if (w % 250 == 249) begin
                run_wave(int'($urandom_range(SHOW - 1, 1)), (w == 499) ? 4 : 3, meas);
                start_game();
            end else if (r < 5) begin
                run_wave(0, 0, meas);
            end else begin
                k = int'($urandom_range(SHOW, 1));
                m = int'($urandom_range(2, 1));
                if (k == SHOW) m = 1;
                run_wave(k, m, meas);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
